neuron_stat_mem_banked: RTL and testbench

Parametrised neuron status store holding NUM_FIELDS per-neuron state fields (bias, membrane potential, threshold, spike history, ...) plus the per-synapse weight array. Sits beside the neuron update pipeline: one registered field read port, one field write port, two registered weight read ports and one weight write port. Adds a hardware clear sequencer that zeroes selected fields across all neurons, plus valid flags on every read port.

---
 rtl/neuron_stat_mem_banked.sv | 185 ++++++++++++++++++
 tb/tb_neuron_stat_mem_banked.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_stat_mem_banked.sv
// Neuron status store: NUM_FIELDS per-neuron field arrays, a weight array with two read ports, and a clear sequencer.
// STAT_MEM_WR_BYPASS_EN selects write-first same-address behaviour; undefined gives read-first.
module neuron_stat_mem_banked #(
  parameter int unsigned NUM_NURNS          = 256,
  parameter int unsigned NUM_AXONS          = 256,
  parameter int unsigned NUM_FIELDS         = 4,
  parameter int unsigned FSEL_BITS          = 2,
  parameter int unsigned DSIZE              = 16,
  parameter int unsigned NURN_CNT_BIT_WIDTH = 8,
  parameter int unsigned AXON_CNT_BIT_WIDTH = 8
) (
  input  logic                                       clk_i,
  input  logic                                       rst_n_i,
  input  logic [NURN_CNT_BIT_WIDTH+FSEL_BITS-1:0]    fld_rd_addr_i,
  input  logic                                       fld_rd_en_i,
  output logic [DSIZE-1:0]                           fld_rd_data_o,
  output logic                                       fld_rd_vld_o,
  input  logic [NURN_CNT_BIT_WIDTH+FSEL_BITS-1:0]    fld_wr_addr_i,
  input  logic                                       fld_wr_en_i,
  input  logic [DSIZE-1:0]                           fld_wr_data_i,
  input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] wt_rd_e_addr_i,
  input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] wt_rd_f_addr_i,
  input  logic                                       wt_rd_e_en_i,
  input  logic                                       wt_rd_f_en_i,
  output logic [DSIZE-1:0]                           wt_rd_e_data_o,
  output logic [DSIZE-1:0]                           wt_rd_f_data_o,
  output logic                                       wt_rd_e_vld_o,
  output logic                                       wt_rd_f_vld_o,
  input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] wt_wr_addr_i,
  input  logic                                       wt_wr_en_i,
  input  logic [DSIZE-1:0]                           wt_wr_data_i,
  input  logic                                       clr_start_i,
  input  logic [NUM_FIELDS-1:0]                      clr_mask_i,
  output logic                                       clr_busy_o,
  output logic                                       clr_done_o
);

  localparam int unsigned NSEL = 1 << FSEL_BITS;
  // Bit f set when field index f is backed by storage.
  localparam logic [NSEL-1:0] FLD_OK = {NSEL{1'b1}} >> (NSEL - NUM_FIELDS);
  localparam logic [NURN_CNT_BIT_WIDTH-1:0] CNT_LAST = NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1);

`ifdef STAT_MEM_WR_BYPASS_EN
  localparam bit WR_BYPASS = 1'b1;
`else
  localparam bit WR_BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} clr_state_e;

  logic [DSIZE-1:0] fld_mem [NUM_FIELDS][NUM_NURNS];
  logic [DSIZE-1:0] wt_mem  [NUM_NURNS*NUM_AXONS];

  clr_state_e                    state_q, state_d;
  logic [NURN_CNT_BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_FIELDS-1:0]         mask_q, mask_d;
  logic                          clr_busy_q, clr_busy_d;
  logic                          clr_done_q, clr_done_d;

  logic [DSIZE-1:0] fld_rd_data_q, fld_rd_data_d;
  logic             fld_rd_vld_q, fld_rd_vld_d;
  logic [DSIZE-1:0] wt_rd_e_data_q, wt_rd_e_data_d;
  logic             wt_rd_e_vld_q, wt_rd_e_vld_d;
  logic [DSIZE-1:0] wt_rd_f_data_q, wt_rd_f_data_d;
  logic             wt_rd_f_vld_q, wt_rd_f_vld_d;

  logic [FSEL_BITS-1:0]          rd_fsel, wr_fsel;
  logic [NURN_CNT_BIT_WIDTH-1:0] rd_nurn, wr_nurn;
  logic                          fld_rd_acc, fld_wr_acc;
  logic [NSEL-1:0]               fld_we;
  logic [NUM_FIELDS-1:0]         clr_we;

  always_comb begin
    rd_fsel    = fld_rd_addr_i[FSEL_BITS-1:0];
    rd_nurn    = fld_rd_addr_i[NURN_CNT_BIT_WIDTH+FSEL_BITS-1:FSEL_BITS];
    wr_fsel    = fld_wr_addr_i[FSEL_BITS-1:0];
    wr_nurn    = fld_wr_addr_i[NURN_CNT_BIT_WIDTH+FSEL_BITS-1:FSEL_BITS];
    fld_rd_acc = fld_rd_en_i && !clr_busy_q;
    fld_wr_acc = fld_wr_en_i && !clr_busy_q && FLD_OK[wr_fsel];
    fld_we          = '0;
    fld_we[wr_fsel] = fld_wr_acc;
    clr_we = (state_q == ST_CLEAR) ? mask_q : '0;
  end

  always_comb begin
    fld_rd_data_d = fld_rd_data_q;
    fld_rd_vld_d  = fld_rd_acc;
    if (fld_rd_acc) begin
      if (!FLD_OK[rd_fsel]) fld_rd_data_d = '0;
      else                  fld_rd_data_d = fld_mem[rd_fsel][rd_nurn];
      if (WR_BYPASS && fld_wr_acc && (fld_wr_addr_i == fld_rd_addr_i))
        fld_rd_data_d = fld_wr_data_i;
    end

    wt_rd_e_data_d = wt_rd_e_data_q;
    wt_rd_e_vld_d  = wt_rd_e_en_i;
    if (wt_rd_e_en_i) begin
      wt_rd_e_data_d = wt_mem[wt_rd_e_addr_i];
      if (WR_BYPASS && wt_wr_en_i && (wt_wr_addr_i == wt_rd_e_addr_i))
        wt_rd_e_data_d = wt_wr_data_i;
    end

    wt_rd_f_data_d = wt_rd_f_data_q;
    wt_rd_f_vld_d  = wt_rd_f_en_i;
    if (wt_rd_f_en_i) begin
      wt_rd_f_data_d = wt_mem[wt_rd_f_addr_i];
      if (WR_BYPASS && wt_wr_en_i && (wt_wr_addr_i == wt_rd_f_addr_i))
        wt_rd_f_data_d = wt_wr_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start_i && (|clr_mask_i)) begin
          mask_d  = clr_mask_i;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with state_q.
    clr_busy_d = (state_d == ST_CLEAR);
    clr_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      mask_q         <= '0;
      clr_busy_q     <= 1'b0;
      clr_done_q     <= 1'b0;
      fld_rd_data_q  <= '0;
      fld_rd_vld_q   <= 1'b0;
      wt_rd_e_data_q <= '0;
      wt_rd_e_vld_q  <= 1'b0;
      wt_rd_f_data_q <= '0;
      wt_rd_f_vld_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      clr_busy_q     <= clr_busy_d;
      clr_done_q     <= clr_done_d;
      fld_rd_data_q  <= fld_rd_data_d;
      fld_rd_vld_q   <= fld_rd_vld_d;
      wt_rd_e_data_q <= wt_rd_e_data_d;
      wt_rd_e_vld_q  <= wt_rd_e_vld_d;
      wt_rd_f_data_q <= wt_rd_f_data_d;
      wt_rd_f_vld_q  <= wt_rd_f_vld_d;
    end
  end

  // Port writes are blocked while clearing, so the two write sources never collide.
  always_ff @(posedge clk_i) begin
    for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
      if (clr_we[f])      fld_mem[f][cnt_q]   <= '0;
      else if (fld_we[f]) fld_mem[f][wr_nurn] <= fld_wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wt_wr_en_i) wt_mem[wt_wr_addr_i] <= wt_wr_data_i;
  end

  assign fld_rd_data_o  = fld_rd_data_q;
  assign fld_rd_vld_o   = fld_rd_vld_q;
  assign wt_rd_e_data_o = wt_rd_e_data_q;
  assign wt_rd_e_vld_o  = wt_rd_e_vld_q;
  assign wt_rd_f_data_o = wt_rd_f_data_q;
  assign wt_rd_f_vld_o  = wt_rd_f_vld_q;
  assign clr_busy_o     = clr_busy_q;
  assign clr_done_o     = clr_done_q;

endmodule

// File: tb/tb_neuron_stat_mem_banked.sv
// Bench for neuron_stat_mem_banked: random traffic against array/associative reference models, clear sweep and reset cases.
module tb_neuron_stat_mem_banked;
  localparam int NN = 256, NF = 4, FB = 2, DS = 16, NB = 8, AB = 8;
  localparam int FA = NB + FB, WA = NB + AB;

`ifdef STAT_MEM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [FA-1:0] fld_rd_addr, fld_wr_addr;
  logic          fld_rd_en, fld_wr_en, fld_rd_vld;
  logic [DS-1:0] fld_wr_data, fld_rd_data;
  logic [WA-1:0] wt_rd_e_addr, wt_rd_f_addr, wt_wr_addr;
  logic          wt_rd_e_en, wt_rd_f_en, wt_wr_en, wt_rd_e_vld, wt_rd_f_vld;
  logic [DS-1:0] wt_wr_data, wt_rd_e_data, wt_rd_f_data;
  logic          clr_start, clr_busy, clr_done;
  logic [NF-1:0] clr_mask;

  logic [FA-1:0] n3_rd_addr, n3_wr_addr;
  logic          n3_rd_en, n3_wr_en, n3_rd_vld, n3_busy, n3_done;
  logic [DS-1:0] n3_wr_data, n3_rd_data, n3_e_data, n3_f_data;
  logic          n3_e_vld, n3_f_vld;

  int checks = 0, failures = 0;
  logic [DS-1:0] fmod [NF][NN];
  logic [DS-1:0] wmod [int];

  neuron_stat_mem_banked #(
    .NUM_NURNS(NN), .NUM_AXONS(256), .NUM_FIELDS(NF), .FSEL_BITS(FB), .DSIZE(DS),
    .NURN_CNT_BIT_WIDTH(NB), .AXON_CNT_BIT_WIDTH(AB)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .fld_rd_addr_i(fld_rd_addr), .fld_rd_en_i(fld_rd_en), .fld_rd_data_o(fld_rd_data), .fld_rd_vld_o(fld_rd_vld),
    .fld_wr_addr_i(fld_wr_addr), .fld_wr_en_i(fld_wr_en), .fld_wr_data_i(fld_wr_data),
    .wt_rd_e_addr_i(wt_rd_e_addr), .wt_rd_f_addr_i(wt_rd_f_addr), .wt_rd_e_en_i(wt_rd_e_en), .wt_rd_f_en_i(wt_rd_f_en),
    .wt_rd_e_data_o(wt_rd_e_data), .wt_rd_f_data_o(wt_rd_f_data), .wt_rd_e_vld_o(wt_rd_e_vld), .wt_rd_f_vld_o(wt_rd_f_vld),
    .wt_wr_addr_i(wt_wr_addr), .wt_wr_en_i(wt_wr_en), .wt_wr_data_i(wt_wr_data),
    .clr_start_i(clr_start), .clr_mask_i(clr_mask), .clr_busy_o(clr_busy), .clr_done_o(clr_done)
  );

  neuron_stat_mem_banked #(
    .NUM_NURNS(NN), .NUM_AXONS(256), .NUM_FIELDS(3), .FSEL_BITS(FB), .DSIZE(DS),
    .NURN_CNT_BIT_WIDTH(NB), .AXON_CNT_BIT_WIDTH(AB)
  ) dut3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .fld_rd_addr_i(n3_rd_addr), .fld_rd_en_i(n3_rd_en), .fld_rd_data_o(n3_rd_data), .fld_rd_vld_o(n3_rd_vld),
    .fld_wr_addr_i(n3_wr_addr), .fld_wr_en_i(n3_wr_en), .fld_wr_data_i(n3_wr_data),
    .wt_rd_e_addr_i('0), .wt_rd_f_addr_i('0), .wt_rd_e_en_i(1'b0), .wt_rd_f_en_i(1'b0),
    .wt_rd_e_data_o(n3_e_data), .wt_rd_f_data_o(n3_f_data), .wt_rd_e_vld_o(n3_e_vld), .wt_rd_f_vld_o(n3_f_vld),
    .wt_wr_addr_i('0), .wt_wr_en_i(1'b0), .wt_wr_data_i('0),
    .clr_start_i(1'b0), .clr_mask_i(3'b000), .clr_busy_o(n3_busy), .clr_done_o(n3_done)
  );

  task automatic idle();
    fld_rd_en = 0; fld_wr_en = 0; wt_rd_e_en = 0; wt_rd_f_en = 0; wt_wr_en = 0;
    clr_start = 0; clr_mask = '0; n3_rd_en = 0; n3_wr_en = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({fld_rd_data, wt_rd_e_data, wt_rd_f_data, n3_rd_data} !== '0) begin
        failures++; $display("FAIL reset_data step=%0d got=%h/%h/%h/%h exp=0", k, fld_rd_data, wt_rd_e_data, wt_rd_f_data, n3_rd_data);
      end
      checks++;
      if ({fld_rd_vld, wt_rd_e_vld, wt_rd_f_vld, clr_busy, clr_done, n3_rd_vld, n3_busy, n3_done} !== '0) begin
        failures++; $display("FAIL reset_flags step=%0d got=%b exp=0", k,
          {fld_rd_vld, wt_rd_e_vld, wt_rd_f_vld, clr_busy, clr_done, n3_rd_vld, n3_busy, n3_done});
      end
      rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_field_rw();
    logic [DS-1:0] exp_d, wd;
    logic          exp_v, re, we;
    logic [FA-1:0] ra, wa;
    // directed: neighbour 0x016 first, then 0x015
    fld_wr_en = 1; fld_wr_addr = 10'h016; fld_wr_data = 16'hAAAA; fmod[2][5] = 16'hAAAA; @(negedge clk);
    fld_wr_addr = 10'h015; fld_wr_data = 16'h1234; fmod[1][5] = 16'h1234; @(negedge clk);
    fld_wr_en = 0; fld_rd_en = 1; fld_rd_addr = 10'h015; @(negedge clk);
    checks++;
    if ({fld_rd_vld, fld_rd_data} !== {1'b1, 16'h1234}) begin
      failures++; $display("FAIL fld_rd_015 got=%b/%h exp=1/1234", fld_rd_vld, fld_rd_data);
    end
    fld_rd_addr = 10'h016; @(negedge clk);
    checks++;
    if ({fld_rd_vld, fld_rd_data} !== {1'b1, 16'hAAAA}) begin
      failures++; $display("FAIL fld_rd_016 got=%b/%h exp=1/aaaa", fld_rd_vld, fld_rd_data);
    end
    fld_rd_en = 0;
    exp_d = 16'hAAAA;
    for (int a = 0; a < NN * NF; a++) begin
      wd = DS'($urandom); fld_wr_en = 1; fld_wr_addr = FA'(a); fld_wr_data = wd;
      fmod[a % NF][a / NF] = wd; @(negedge clk);
    end
    fld_wr_en = 0;
    exp_v = 1'b0;
    for (int i = 0; i < 301; i++) begin
      if (i > 0) begin
        checks++;
        if ({fld_rd_vld, fld_rd_data} !== {exp_v, exp_d}) begin
          failures++; $display("FAIL fld_random i=%0d got=%b/%h exp=%b/%h", i, fld_rd_vld, fld_rd_data, exp_v, exp_d);
        end
      end
      re = (i < 300) && ($urandom_range(0, 2) != 0);
      we = (i < 300) && ($urandom_range(0, 1) != 0);
      ra = FA'($urandom); wd = DS'($urandom);
      wa = ($urandom_range(0, 3) == 0) ? ra : FA'($urandom);
      exp_v = re;
      if (re) exp_d = (BYP && we && wa == ra) ? wd : fmod[ra % NF][ra / NF];
      if (we) fmod[wa % NF][wa / NF] = wd;
      fld_rd_en = re; fld_rd_addr = ra; fld_wr_en = we; fld_wr_addr = wa; fld_wr_data = wd;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_weights();
    logic [WA-1:0] pool [16];
    logic [WA-1:0] ea, fa, ga;
    logic [DS-1:0] exp_e, exp_f, gd;
    logic          ee, fe, ge, vexp_e, vexp_f;
    wt_wr_en = 1; wt_wr_addr = 16'h0A03; wt_wr_data = 16'hBEEF; wmod[16'h0A03] = 16'hBEEF; @(negedge clk);
    wt_wr_en = 0; wt_rd_e_en = 1; wt_rd_f_en = 1; wt_rd_e_addr = 16'h0A03; wt_rd_f_addr = 16'h0A03; @(negedge clk);
    checks++;
    if ({wt_rd_e_vld, wt_rd_e_data, wt_rd_f_vld, wt_rd_f_data} !== {1'b1, 16'hBEEF, 1'b1, 16'hBEEF}) begin
      failures++; $display("FAIL wt_ef_same got=%b/%h %b/%h exp=1/beef", wt_rd_e_vld, wt_rd_e_data, wt_rd_f_vld, wt_rd_f_data);
    end
    exp_e = 16'hBEEF; exp_f = 16'hBEEF;
    pool[0] = 16'h0A03;
    for (int k = 1; k < 16; k++) pool[k] = WA'($urandom);
    for (int k = 1; k < 16; k++) begin
      gd = DS'($urandom); wt_wr_en = 1; wt_wr_addr = pool[k]; wt_wr_data = gd; wmod[int'(pool[k])] = gd;
      wt_rd_e_en = 0; wt_rd_f_en = 0; @(negedge clk);
    end
    vexp_e = 0; vexp_f = 0;
    for (int i = 0; i < 301; i++) begin
      if (i > 0) begin
        checks++;
        if ({wt_rd_e_vld, wt_rd_e_data, wt_rd_f_vld, wt_rd_f_data} !== {vexp_e, exp_e, vexp_f, exp_f}) begin
          failures++; $display("FAIL wt_random i=%0d got=%b/%h %b/%h exp=%b/%h %b/%h", i, wt_rd_e_vld, wt_rd_e_data,
            wt_rd_f_vld, wt_rd_f_data, vexp_e, exp_e, vexp_f, exp_f);
        end
      end
      ee = (i < 300) && ($urandom_range(0, 2) != 0);
      fe = (i < 300) && ($urandom_range(0, 2) != 0);
      ge = (i < 300) && ($urandom_range(0, 1) != 0);
      ea = pool[$urandom_range(0, 15)]; fa = pool[$urandom_range(0, 15)]; ga = pool[$urandom_range(0, 15)];
      gd = DS'($urandom);
      vexp_e = ee; vexp_f = fe;
      if (ee) exp_e = (BYP && ge && ga == ea) ? gd : wmod[int'(ea)];
      if (fe) exp_f = (BYP && ge && ga == fa) ? gd : wmod[int'(fa)];
      if (ge) wmod[int'(ga)] = gd;
      wt_rd_e_en = ee; wt_rd_e_addr = ea; wt_rd_f_en = fe; wt_rd_f_addr = fa;
      wt_wr_en = ge; wt_wr_addr = ga; wt_wr_data = gd;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_bypass();
    logic [DS-1:0] exp;
    wt_wr_en = 1; wt_wr_addr = 16'h0A03; wt_wr_data = 16'hBEEF; @(negedge clk);
    wt_wr_data = 16'h0001; wt_rd_e_en = 1; wt_rd_f_en = 1; wt_rd_e_addr = 16'h0A03; wt_rd_f_addr = 16'h0A03;
    @(negedge clk);
    wt_wr_en = 0; wmod[16'h0A03] = 16'h0001;
    exp = BYP ? 16'h0001 : 16'hBEEF;
    checks++;
    if ({wt_rd_e_data, wt_rd_f_data} !== {exp, exp}) begin
      failures++; $display("FAIL wt_same_cycle got=%h/%h exp=%h", wt_rd_e_data, wt_rd_f_data, exp);
    end
    @(negedge clk);
    checks++;
    if ({wt_rd_e_data, wt_rd_f_data} !== {16'h0001, 16'h0001}) begin
      failures++; $display("FAIL wt_after_write got=%h/%h exp=0001", wt_rd_e_data, wt_rd_f_data);
    end
    wt_rd_e_en = 0; wt_rd_f_en = 0;
    fld_wr_en = 1; fld_wr_addr = 10'h015; fld_wr_data = 16'h4321; fld_rd_en = 1; fld_rd_addr = 10'h015;
    exp = BYP ? 16'h4321 : fmod[1][5];
    fmod[1][5] = 16'h4321;
    @(negedge clk);
    checks++;
    if ({fld_rd_vld, fld_rd_data} !== {1'b1, exp}) begin
      failures++; $display("FAIL fld_same_cycle got=%b/%h exp=1/%h", fld_rd_vld, fld_rd_data, exp);
    end
    idle();
  endtask

  task automatic test_clear();
    int busy_n, done_n, first_busy, last_busy, done_idx;
    for (int a = 0; a < NN * NF; a++) begin
      fld_wr_en = 1; fld_wr_addr = FA'(a); fld_wr_data = 16'hFFFF; fmod[a % NF][a / NF] = 16'hFFFF; @(negedge clk);
    end
    fld_wr_en = 0;
    clr_start = 1; clr_mask = '0; @(negedge clk);
    clr_start = 0;
    busy_n = int'(clr_busy);
    repeat (3) begin @(negedge clk); busy_n += int'(clr_busy); end
    checks++;
    if (busy_n !== 0) begin failures++; $display("FAIL clr_zero_mask busy_cycles got=%0d exp=0", busy_n); end
    clr_start = 1; clr_mask = 4'b0010; @(negedge clk);
    clr_start = 0; clr_mask = '0;
    busy_n = 0; done_n = 0; first_busy = -1; last_busy = -1; done_idx = -1;
    for (int i = 0; i < 300; i++) begin
      if (clr_busy) begin busy_n++; if (first_busy < 0) first_busy = i; last_busy = i; end
      if (clr_done) begin done_n++; done_idx = i; end
      if (i == 13) begin
        checks++;
        if (fld_rd_vld !== 1'b0) begin failures++; $display("FAIL clr_read_during_busy vld got=%b exp=0", fld_rd_vld); end
      end
      fld_wr_en = 0; fld_rd_en = 0; clr_start = 0; clr_mask = '0;
      if (i == 10) begin fld_wr_en = 1; fld_wr_addr = 10'h015; fld_wr_data = 16'h5555; end
      if (i == 11) begin fld_wr_en = 1; fld_wr_addr = 10'h01C; fld_wr_data = 16'h0000; end
      if (i == 12) begin fld_rd_en = 1; fld_rd_addr = 10'h015; end
      if (i == 20) begin clr_start = 1; clr_mask = 4'b1111; end
      @(negedge clk);
    end
    checks++;
    if (busy_n !== NN || first_busy !== 0) begin
      failures++; $display("FAIL clr_busy_len got=%0d first=%0d exp=%0d first=0", busy_n, first_busy, NN);
    end
    checks++;
    if (done_n !== 1 || done_idx !== last_busy + 1) begin
      failures++; $display("FAIL clr_done_pulse got=%0d at=%0d exp=1 at=%0d", done_n, done_idx, last_busy + 1);
    end
    for (int n = 0; n < NN; n++) fmod[1][n] = '0;
    for (int a = 0; a < NN * NF; a++) begin
      fld_rd_en = 1; fld_rd_addr = FA'(a); @(negedge clk);
      checks++;
      if ({fld_rd_vld, fld_rd_data} !== {1'b1, fmod[a % NF][a / NF]}) begin
        failures++; $display("FAIL clr_readback addr=%h got=%b/%h exp=1/%h", a, fld_rd_vld, fld_rd_data, fmod[a % NF][a / NF]);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    int busy_n, done_n;
    logic [FA-1:0] ra;
    clr_start = 1; clr_mask = 4'b0001; wt_rd_e_en = 1; wt_rd_e_addr = 16'h0A03; @(negedge clk);
    clr_start = 0; clr_mask = '0;
    repeat (100) @(negedge clk);
    checks++;
    if ({clr_busy, wt_rd_e_vld} !== 2'b11) begin
      failures++; $display("FAIL midsweep_pre busy/vld got=%b%b exp=11", clr_busy, wt_rd_e_vld);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({clr_busy, clr_done, fld_rd_vld, wt_rd_e_vld, wt_rd_f_vld} !== 5'b0) begin
      failures++; $display("FAIL midsweep_reset got=%b exp=00000", {clr_busy, clr_done, fld_rd_vld, wt_rd_e_vld, wt_rd_f_vld});
    end
    @(negedge clk);
    idle(); rst_n = 1'b1;
    @(negedge clk);
    clr_start = 1; clr_mask = 4'b1111; @(negedge clk);
    clr_start = 0; clr_mask = '0;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 300; i++) begin
      busy_n += int'(clr_busy); done_n += int'(clr_done); @(negedge clk);
    end
    checks++;
    if (busy_n !== NN || done_n !== 1) begin
      failures++; $display("FAIL midsweep_restart busy=%0d done=%0d exp=%0d/1", busy_n, done_n, NN);
    end
    for (int k = 0; k < 32; k++) begin
      ra = FA'($urandom); fld_rd_en = 1; fld_rd_addr = ra; @(negedge clk);
      checks++;
      if ({fld_rd_vld, fld_rd_data} !== {1'b1, 16'h0000}) begin
        failures++; $display("FAIL full_clear addr=%h got=%b/%h exp=1/0000", ra, fld_rd_vld, fld_rd_data);
      end
    end
    idle();
  endtask

  task automatic test_three_fields();
    n3_wr_en = 1; n3_wr_addr = 10'h016; n3_wr_data = 16'h00AB; @(negedge clk);
    n3_wr_addr = 10'h017; n3_wr_data = 16'h7777; @(negedge clk);
    n3_wr_en = 0; n3_rd_en = 1; n3_rd_addr = 10'h016; @(negedge clk);
    checks++;
    if ({n3_rd_vld, n3_rd_data} !== {1'b1, 16'h00AB}) begin
      failures++; $display("FAIL nf3_field2 got=%b/%h exp=1/00ab", n3_rd_vld, n3_rd_data);
    end
    n3_rd_addr = 10'h017; @(negedge clk);
    checks++;
    if ({n3_rd_vld, n3_rd_data} !== {1'b1, 16'h0000}) begin
      failures++; $display("FAIL nf3_field3 got=%b/%h exp=1/0000", n3_rd_vld, n3_rd_data);
    end
    n3_rd_en = 0; @(negedge clk);
    checks++;
    if ({n3_rd_vld, n3_rd_data} !== {1'b0, 16'h0000}) begin
      failures++; $display("FAIL nf3_hold got=%b/%h exp=0/0000", n3_rd_vld, n3_rd_data);
    end
  endtask

  initial begin
    fld_rd_addr = '0; fld_wr_addr = '0; fld_wr_data = '0;
    wt_rd_e_addr = '0; wt_rd_f_addr = '0; wt_wr_addr = '0; wt_wr_data = '0;
    n3_rd_addr = '0; n3_wr_addr = '0; n3_wr_data = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_field_rw();
    test_weights();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
    test_three_fields();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
